w5300_bus_if: RTL
=================

W5300_BUS_IF -- requirements
Module: w5300_bus_if

Interface
REQ-001 Parameter CLK_FREQ, default 100, clock frequency in MHz; sets cycles per microsecond.
REQ-002 Parameter RST_LOW_US, default 2, W5300 hardware reset low time in microseconds.
REQ-003 Parameter RST_WAIT_US, default 10000, PLL-lock wait after reset release in microseconds.
REQ-004 Parameter SETUP_CYC, default 1, cycles from address/CS valid to strobe low; minimum 1.
REQ-005 Parameter RD_PULSE_CYC, default 7, RD_n low width in cycles; minimum 1.
REQ-006 Parameter WR_PULSE_CYC, default 5, WR_n low width in cycles; minimum 1.
REQ-007 Parameter HOLD_CYC, default 1, cycles from strobe high to CS_n high; minimum 1.
REQ-008 Parameter RECOV_CYC, default 3, caddr-ignore cycles after each completion; minimum 3.
REQ-009 clk  in  1  single system clock; all logic on its rising edge.
REQ-010 rst  in  1  reset, synchronous, active-high.
REQ-011 caddr  in  12  command: [11] 0 = valid / 1 = invalid; [10] 1 = read / 0 = write; [9:0] W5300 address.
REQ-012 wr_data  in  16  write data; sampled with caddr.
REQ-013 rd_data  out  16  last completed read data.
REQ-014 op_status  out  1  one-cycle pulse: reset sequence done, or bus cycle done.
REQ-015 w5300_rst_n  out  1  W5300 hardware reset, active-low.
REQ-016 w5300_cs_n, w5300_rd_n, w5300_wr_n  out  1 each  bus strobes, active-low.
REQ-017 w5300_addr  out  10  bus address.
REQ-018 w5300_data_o  out  16  bus write data.
REQ-019 w5300_data_oe  out  1  1 = drive data bus; the top level builds the tristate.
REQ-020 w5300_data_i  in  16  bus read data.

Function
REQ-021 FSM states: S_RST_LOW, S_RST_WAIT, S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOV.
REQ-022 S_RST_LOW holds w5300_rst_n=0 for CLK_FREQ*RST_LOW_US cycles, then enters S_RST_WAIT.
REQ-023 S_RST_WAIT holds w5300_rst_n=1 for CLK_FREQ*RST_WAIT_US cycles, then enters S_RECOV with op_status=1 for that first S_RECOV cycle.
REQ-024 The shared cycle counter shall be 24 bits wide; product overflow is a parameter error, not handled.
REQ-025 caddr is ignored in every state except S_IDLE.
REQ-026 In S_IDLE with caddr[11]=0: latch caddr[10:0] and wr_data, then enter S_SETUP.
REQ-027 In S_IDLE with caddr[11]=1: remain in S_IDLE.
REQ-028 S_SETUP, SETUP_CYC cycles: cs_n=0, rd_n=wr_n=1, addr driven; for writes, data_o=latched data and data_oe=1.
REQ-029 S_STROBE, RD_PULSE_CYC or WR_PULSE_CYC cycles: the rd_n or wr_n strobe is 0; cs_n, addr and data are unchanged.
REQ-030 For a read, rd_data captures w5300_data_i on the last S_STROBE cycle.
REQ-031 S_HOLD, HOLD_CYC cycles: strobe=1; cs_n, addr and data_oe are unchanged.
REQ-032 On leaving S_HOLD: cs_n=1 and data_oe=0, then enter S_RECOV with op_status=1 for exactly its first cycle.
REQ-033 S_RECOV lasts RECOV_CYC cycles, then enters S_IDLE; this guarantees a consumer's stale caddr is not reissued.
REQ-034 Latency uses defaults; t is the S_IDLE cycle in which caddr is sampled. A write pulses op_status at t+8; a read pulses at t+10.
REQ-035 A caddr held valid with the same value causes back-to-back repeated cycles, one per completion plus RECOV_CYC; this supports polling.
REQ-036 Writes never change rd_data; rd_data holds until the next read completes.
REQ-037 rd_n and wr_n are never low simultaneously; data_oe is never 1 during a read.
REQ-038 All outputs are registered and glitch-free.

Reset
REQ-039 While rst=1, at each clock edge: w5300_rst_n=0, cs_n=rd_n=wr_n=1, addr=0, data_o=0, data_oe=0, op_status=0, rd_data=0, state=S_RST_LOW, counter=0.
REQ-040 rst asserted mid-bus-cycle aborts the cycle at the next edge, with no op_status; the full hardware-reset sequence restarts.

Verification
REQ-041 Parameters CLK_FREQ=1, RST_LOW_US=4, RST_WAIT_US=10; release rst -> w5300_rst_n low 4 cycles, high 10 cycles, then a single op_status pulse.
REQ-042 Write caddr=0x008, wr_data=0xB800, default timing -> cs_n low 7 cycles, wr_n low 5 cycles, addr=0x008, data_o=0xB800 with oe=1, op_status at t+8.
REQ-043 Read caddr=0x608, w5300_data_i=0x0022 -> rd_n low 7 cycles, oe=0 throughout, rd_data=0x0022, op_status at t+10.
REQ-044 Consumer model changes caddr 2 cycles after op_status -> no duplicate bus cycle on the old address.
REQ-045 caddr=0xFFF throughout -> no bus activity after the reset sequence.
REQ-046 rst pulsed during S_STROBE of a write -> wr_n=1 and cs_n=1 next edge, no op_status, reset sequence reruns.

Source files
------------

// File: rtl/w5300_bus_if.sv
// W5300 parallel-bus host interface: hardware-reset/PLL-lock sequencing, then
// single-word read/write bus cycles with programmable setup, strobe, hold and recovery.
module w5300_bus_if #(
   parameter int unsigned CLK_FREQ     = 100,
   parameter int unsigned RST_LOW_US   = 2,
   parameter int unsigned RST_WAIT_US  = 10000,
   parameter int unsigned SETUP_CYC    = 1,
   parameter int unsigned RD_PULSE_CYC = 7,
   parameter int unsigned WR_PULSE_CYC = 5,
   parameter int unsigned HOLD_CYC     = 1,
   parameter int unsigned RECOV_CYC    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] caddr,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        op_status,
   output logic        w5300_rst_n,
   output logic        w5300_cs_n,
   output logic        w5300_rd_n,
   output logic        w5300_wr_n,
   output logic [9:0]  w5300_addr,
   output logic [15:0] w5300_data_o,
   output logic        w5300_data_oe,
   input  logic [15:0] w5300_data_i
);

   typedef enum logic [2:0] {
      S_RST_LOW, S_RST_WAIT, S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOV
   } state_e;

   localparam logic [23:0] RstLowCyc  = 24'(CLK_FREQ * RST_LOW_US);
   localparam logic [23:0] RstWaitCyc = 24'(CLK_FREQ * RST_WAIT_US);
   localparam logic [23:0] SetupCyc   = 24'(SETUP_CYC);
   localparam logic [23:0] RdCyc      = 24'(RD_PULSE_CYC);
   localparam logic [23:0] WrCyc      = 24'(WR_PULSE_CYC);
   localparam logic [23:0] HoldCyc    = 24'(HOLD_CYC);
   localparam logic [23:0] RecovCyc   = 24'(RECOV_CYC);

   state_e      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic [23:0] len;
   logic        last;
   logic [10:0] cmd_q, cmd_d;
   logic [15:0] wdat_q, wdat_d;

   logic        active;
   logic        rst_n_d, cs_n_d, rd_n_d, wr_n_d, oe_d, op_d;
   logic [9:0]  addr_d;
   logic [15:0] data_o_d, rd_data_d;

   // State register with the shared cycle counter and latched command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RST_LOW;
         cnt_q   <= '0;
         cmd_q   <= '0;
         wdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         wdat_q  <= wdat_d;
      end
   end

   always_comb begin
      len = 24'd1;
      unique case (state_q)
         S_RST_LOW:  len = RstLowCyc;
         S_RST_WAIT: len = RstWaitCyc;
         S_SETUP:    len = SetupCyc;
         S_STROBE:   len = cmd_q[10] ? RdCyc : WrCyc;
         S_HOLD:     len = HoldCyc;
         S_RECOV:    len = RecovCyc;
         default:    len = 24'd1;
      endcase
   end

   assign last = (cnt_q == len - 24'd1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 24'd1;
      cmd_d   = cmd_q;
      wdat_d  = wdat_q;
      unique case (state_q)
         S_RST_LOW:  if (last) state_d = S_RST_WAIT;
         S_RST_WAIT: if (last) state_d = S_RECOV;
         S_IDLE: begin
            if (!caddr[11]) begin
               cmd_d   = caddr[10:0];
               wdat_d  = wr_data;
               state_d = S_SETUP;
            end
         end
         S_SETUP:    if (last) state_d = S_STROBE;
         S_STROBE:   if (last) state_d = S_HOLD;
         S_HOLD:     if (last) state_d = S_RECOV;
         S_RECOV:    if (last) state_d = S_IDLE;
         default:    state_d = S_RST_LOW;
      endcase
      if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
   end

   // Outputs are decoded from the next state so the registered pins line up
   // with the state they belong to.
   always_comb begin
      active    = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      rst_n_d   = (state_d != S_RST_LOW);
      cs_n_d    = !active;
      rd_n_d    = !((state_d == S_STROBE) && cmd_d[10]);
      wr_n_d    = !((state_d == S_STROBE) && !cmd_d[10]);
      oe_d      = active && !cmd_d[10];
      addr_d    = active ? cmd_d[9:0] : w5300_addr;
      data_o_d  = oe_d ? wdat_d : w5300_data_o;
      op_d      = (state_d == S_RECOV) && (state_q != S_RECOV);
      rd_data_d = rd_data;
      if (state_q == S_STROBE && last && cmd_q[10]) rd_data_d = w5300_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w5300_rst_n   <= 1'b0;
         w5300_cs_n    <= 1'b1;
         w5300_rd_n    <= 1'b1;
         w5300_wr_n    <= 1'b1;
         w5300_addr    <= '0;
         w5300_data_o  <= '0;
         w5300_data_oe <= 1'b0;
         op_status     <= 1'b0;
         rd_data       <= '0;
      end else begin
         w5300_rst_n   <= rst_n_d;
         w5300_cs_n    <= cs_n_d;
         w5300_rd_n    <= rd_n_d;
         w5300_wr_n    <= wr_n_d;
         w5300_addr    <= addr_d;
         w5300_data_o  <= data_o_d;
         w5300_data_oe <= oe_d;
         op_status     <= op_d;
         rd_data       <= rd_data_d;
      end
   end

endmodule
